// File: rtl/seg_display_scanner.sv
// Debug-value display: re-times and debounces {strings, regs}, then scans the 16-bit value onto a
// 4-digit common-anode hex display. Define LEAD_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned STABLE_CNT  = 4
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic [15:0] regs_i,
  input  logic [7:0]  strings_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [7:0]  led_o,
  output logic        update_o
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CntLoad   = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CntMax    = CW'(STABLE_CNT);

  logic [23:0]   s1_q, s2_q, s3_q, latch_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q, idx_d;
  logic          active_q, fresh_q;
  logic          stable, load, tick, wrap, blank;
  logic [3:0]    nibble;
  logic [6:0]    seg_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    stable = (s2_q == s3_q);
    load   = stable && (cnt_q == CntLoad) && (s2_q != latch_q);
    tick   = (presc_q == PrescLast);
    // The first tick after reset only activates the scan; digit 0 is shown without advancing.
    idx_d  = active_q ? idx_q + 2'd1 : 2'd0;
    wrap   = tick && active_q && (idx_q == 2'd3);
    nibble = 4'h0;
    blank  = 1'b0;
    unique case (idx_d)
      2'd0: nibble = latch_q[3:0];
      2'd1: nibble = latch_q[7:4];
      2'd2: nibble = latch_q[11:8];
      2'd3: nibble = latch_q[15:12];
      default: nibble = 4'h0;
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    unique case (idx_d)
      2'd1: blank = (latch_q[15:4] == 12'h000);
      2'd2: blank = (latch_q[15:8] == 8'h00);
      2'd3: blank = (latch_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    seg_d = blank ? 7'h7F : hex_to_seg(nibble);
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      cnt_q    <= '0;
      latch_q  <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      fresh_q  <= 1'b0;
      update_o <= 1'b0;
      an_o     <= 4'hF;
      seg_o    <= 7'h7F;
      dp_o     <= 1'b1;
    end else begin
      s1_q <= {strings_i, regs_i};
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (!stable) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CW'(1);
      end
      update_o <= load;
      if (load) begin
        latch_q <= s2_q;
      end
      // A load on the wrapping edge keeps the value marked fresh for the coming frame.
      if (load) begin
        fresh_q <= 1'b1;
      end else if (wrap) begin
        fresh_q <= 1'b0;
      end
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        active_q <= 1'b1;
        idx_q    <= idx_d;
        an_o     <= ~(4'b0001 << idx_d);
        seg_o    <= seg_d;
        dp_o     <= !((idx_d == 2'd0) && fresh_q);
      end
    end
  end

  assign led_o = latch_q[23:16];

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with REFRESH_DIV=4, STABLE_CNT=4.
module tb_seg_display_scanner;

  logic        clock = 1'b0;
  logic        reset_i;
  logic [15:0] regs_i;
  logic [7:0]  strings_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  led_o;
  logic        update_o;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  seg_display_scanner #(
    .REFRESH_DIV(4),
    .STABLE_CNT (4)
  ) dut (
    .clock    (clock),
    .reset_i  (reset_i),
    .regs_i   (regs_i),
    .strings_i(strings_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .led_o    (led_o),
    .update_o (update_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, sampling 1 time unit after each, and tally update pulses.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (update_o === 1'b1) pulses++;
    end
  endtask

  // Stop right after the edge on which an_o switches to target (bounded).
  task automatic wait_anode(input logic [3:0] target);
    logic [3:0] prev;
    for (int i = 0; i < 40; i++) begin
      prev = an_o;
      adv(1);
      if (an_o === target && prev !== target) break;
    end
    check("wait_anode", 24'(an_o), 24'(target));
  endtask

  logic [6:0] hi_blank;

  initial begin
`ifdef LEAD_ZERO_BLANK_EN
    hi_blank = 7'h7F;
`else
    hi_blank = 7'h40;
`endif
    reset_i   = 1'b0;
    regs_i    = 16'h0000;
    strings_i = 8'h00;
    adv(2);
    check("rst_an",  24'(an_o),     24'hF);
    check("rst_seg", 24'(seg_o),    24'h7F);
    check("rst_dp",  24'(dp_o),     24'h1);
    check("rst_led", 24'(led_o),    24'h0);
    check("rst_upd", 24'(update_o), 24'h0);

    // Release with a new value; first sampling edge is E1.
    reset_i   = 1'b1;
    regs_i    = 16'h1A2F;
    strings_i = 8'hA5;
    adv(3);
    check("e3_an_idle", 24'(an_o), 24'hF);
    adv(1);
    check("e4_an",  24'(an_o),  24'hE);
    check("e4_seg", 24'(seg_o), 24'h40);
    check("e4_dp",  24'(dp_o),  24'h1);
    adv(2);
    check("e6_upd", 24'(update_o), 24'h0);
    check("e6_led", 24'(led_o),    24'h00);
    adv(1);
    check("e7_upd", 24'(update_o), 24'h1);
    check("e7_led", 24'(led_o),    24'hA5);
    adv(1);
    check("e8_upd", 24'(update_o), 24'h0);
    check("e8_an",  24'(an_o),  24'hD);
    check("e8_seg", 24'(seg_o), 24'h24);
    adv(4);
    check("e12_an",  24'(an_o),  24'hB);
    check("e12_seg", 24'(seg_o), 24'h08);
    adv(4);
    check("e16_an",  24'(an_o),  24'h7);
    check("e16_seg", 24'(seg_o), 24'h79);
    adv(4);
    check("e20_an",  24'(an_o),  24'hE);
    check("e20_seg", 24'(seg_o), 24'h0E);
    check("e20_dp",  24'(dp_o),  24'h0);
    adv(3);
    check("e23_an_hold", 24'(an_o), 24'hE);
    check("e23_dp_hold", 24'(dp_o), 24'h0);
    adv(1);
    check("e24_an",  24'(an_o),  24'hD);
    check("e24_seg", 24'(seg_o), 24'h24);
    adv(12);
    check("e36_an",  24'(an_o),  24'hE);
    check("e36_seg", 24'(seg_o), 24'h0E);
    check("e36_dp",  24'(dp_o),  24'h1);

    // Glitch filter: toggle every 3 clocks, ending on 0x5678.
    pulses = 0;
    for (int s = 0; s < 14; s++) begin
      regs_i = (s % 2 == 0) ? 16'h1234 : 16'h5678;
      adv(3);
    end
    check("glitch_no_upd", 24'(pulses), 24'd0);
    pulses = 0;
    adv(20);
    check("settle_one_upd", 24'(pulses), 24'd1);
    wait_anode(4'hE);
    check("g_d0", 24'(seg_o), 24'h00);
    adv(4);
    check("g_d1", 24'(seg_o), 24'h78);
    adv(4);
    check("g_d2", 24'(seg_o), 24'h02);
    adv(4);
    check("g_d3", 24'(seg_o), 24'h12);
    check("g_led", 24'(led_o), 24'hA5);

    // Short glitch then re-present the latched value.
    pulses = 0;
    regs_i = 16'h1234;
    adv(2);
    regs_i = 16'h5678;
    adv(20);
    check("dup_no_upd", 24'(pulses), 24'd0);
    wait_anode(4'hE);
    check("dup_d0", 24'(seg_o), 24'h00);
    adv(4);
    check("dup_d1", 24'(seg_o), 24'h78);

    // Leading zeros.
    pulses    = 0;
    regs_i    = 16'h0042;
    strings_i = 8'h3C;
    adv(12);
    check("lz_upd", 24'(pulses), 24'd1);
    check("lz_led", 24'(led_o),  24'h3C);
    wait_anode(4'hE);
    check("lz_d0", 24'(seg_o), 24'h24);
    adv(4);
    check("lz_d1", 24'(seg_o), 24'h19);
    adv(4);
    check("lz_d2", 24'(seg_o), 24'(hi_blank));
    adv(4);
    check("lz_d3_an", 24'(an_o),  24'h7);
    check("lz_d3",    24'(seg_o), 24'(hi_blank));

    // Asynchronous reset mid-scan.
    adv(2);
    reset_i = 1'b0;
    #1;
    check("mid_rst_an",  24'(an_o),  24'hF);
    check("mid_rst_seg", 24'(seg_o), 24'h7F);
    check("mid_rst_dp",  24'(dp_o),  24'h1);
    check("mid_rst_led", 24'(led_o), 24'h00);
    adv(2);
    reset_i = 1'b1;
    adv(3);
    check("rel_an_idle", 24'(an_o), 24'hF);
    adv(1);
    check("rel_an",  24'(an_o),  24'hE);
    check("rel_seg", 24'(seg_o), 24'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
